// File: rtl/ifu_fetch.sv
// Instruction fetch unit: drives the fetch pc, registers the returned word with
// its address, flags misaligned/out-of-window fetches and counts handoffs.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instr_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        d_ready,
    output logic        f_valid,
    output logic [31:0] f_instr,
    output logic [31:0] f_pc,
    output logic        f_exc,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] WINDOW_BYTES = 32'(4 * IM_WORDS);

    logic [31:0] pc_offset;
    logic        pc_legal;
    logic        load;
    logic        handoff;

    // Unsigned offset compare also rejects addresses below RESET_PC, since they wrap high.
    always_comb begin
        pc_offset = pc - RESET_PC;
        pc_legal  = (pc[1:0] == 2'b00) && (pc_offset < WINDOW_BYTES);
        load      = !redirect && (!f_valid || d_ready);
        handoff   = !redirect && f_valid && d_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            f_valid <= 1'b0;
            f_instr <= 32'h0000_0000;
            f_pc    <= 32'h0000_0000;
            f_exc   <= 1'b0;
        end else if (redirect) begin
            pc      <= redirect_pc;
            f_valid <= 1'b0;
        end else if (load) begin
            pc      <= pc + 32'd4;
            f_valid <= 1'b1;
            f_pc    <= pc;
            f_instr <= pc_legal ? instr_in : 32'h0000_0000;
            f_exc   <= !pc_legal;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= 32'h0000_0000;
        end else if (handoff) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed, table-driven bench for ifu_fetch with a combinational memory model
// and hand-written sequences for asynchronous reset and counter wrap.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr_in;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        d_ready;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic        f_exc;
    logic [31:0] fetch_cnt;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        d_ready;
        logic        e_valid;
        logic [31:0] e_fpc;
        logic [31:0] e_instr;
        logic        e_exc;
        logic [31:0] e_cnt;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    ifu_fetch #(.RESET_PC(32'h0000_3000), .IM_WORDS(4096)) dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .instr_in(instr_in),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .d_ready(d_ready),
        .f_valid(f_valid),
        .f_instr(f_instr),
        .f_pc(f_pc),
        .f_exc(f_exc),
        .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign instr_in = mem_word(pc);

    function automatic void add(input logic r, input logic [31:0] rpc, input logic d,
                                input logic v, input logic [31:0] fpc, input logic [31:0] ins,
                                input logic exc, input logic [31:0] cnt, input logic [31:0] npc);
        vec_t t;
        t.redirect = r;   t.rpc = rpc;     t.d_ready = d;
        t.e_valid  = v;   t.e_fpc = fpc;   t.e_instr = ins;
        t.e_exc    = exc; t.e_cnt = cnt;   t.e_pc = npc;
        vecs.push_back(t);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic checkAll(input string tag, input logic v, input logic [31:0] fpc,
                            input logic [31:0] ins, input logic exc, input logic [31:0] cnt,
                            input logic [31:0] npc);
        checkOutput({tag, ".f_valid"},   {31'd0, f_valid}, {31'd0, v});
        checkOutput({tag, ".f_pc"},      f_pc, fpc);
        checkOutput({tag, ".f_instr"},   f_instr, ins);
        checkOutput({tag, ".f_exc"},     {31'd0, f_exc}, {31'd0, exc});
        checkOutput({tag, ".fetch_cnt"}, fetch_cnt, cnt);
        checkOutput({tag, ".pc"},        pc, npc);
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] rpc, input logic d);
        redirect    = r;
        redirect_pc = rpc;
        d_ready     = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        d_ready     = 1'b1;

        // Streaming from reset, then redirects, stalls, illegal addresses and pc wrap.
        add(0, 0, 1,  1, 32'h3000, mem_word(32'h3000), 0, 0, 32'h3004);
        add(0, 0, 1,  1, 32'h3004, mem_word(32'h3004), 0, 1, 32'h3008);
        add(0, 0, 1,  1, 32'h3008, mem_word(32'h3008), 0, 2, 32'h300C);
        add(0, 0, 1,  1, 32'h300C, mem_word(32'h300C), 0, 3, 32'h3010);
        add(1, 32'h3100, 1,  0, 32'h300C, mem_word(32'h300C), 0, 3, 32'h3100);
        add(0, 0, 1,  1, 32'h3100, mem_word(32'h3100), 0, 3, 32'h3104);
        add(1, 32'h3004, 0,  0, 32'h3100, mem_word(32'h3100), 0, 3, 32'h3004);
        add(0, 0, 0,  1, 32'h3004, mem_word(32'h3004), 0, 3, 32'h3008);
        add(0, 0, 0,  1, 32'h3004, mem_word(32'h3004), 0, 3, 32'h3008);
        add(0, 0, 0,  1, 32'h3004, mem_word(32'h3004), 0, 3, 32'h3008);
        add(0, 0, 0,  1, 32'h3004, mem_word(32'h3004), 0, 3, 32'h3008);
        add(0, 0, 1,  1, 32'h3008, mem_word(32'h3008), 0, 4, 32'h300C);
        add(1, 32'h3102, 1,  0, 32'h3008, mem_word(32'h3008), 0, 4, 32'h3102);
        add(0, 0, 0,  1, 32'h3102, 32'h0, 1, 4, 32'h3106);
        add(1, 32'h7000, 0,  0, 32'h3102, 32'h0, 1, 4, 32'h7000);
        add(0, 0, 1,  1, 32'h7000, 32'h0, 1, 4, 32'h7004);
        add(1, 32'h6FFC, 1,  0, 32'h7000, 32'h0, 1, 4, 32'h6FFC);
        add(0, 0, 1,  1, 32'h6FFC, mem_word(32'h6FFC), 0, 4, 32'h7000);
        add(0, 0, 1,  1, 32'h7000, 32'h0, 1, 5, 32'h7004);
        add(1, 32'h2FFC, 0,  0, 32'h7000, 32'h0, 1, 5, 32'h2FFC);
        add(0, 0, 1,  1, 32'h2FFC, 32'h0, 1, 5, 32'h3000);
        add(0, 0, 1,  1, 32'h3000, mem_word(32'h3000), 0, 6, 32'h3004);
        add(1, 32'hFFFF_FFFC, 1,  0, 32'h3000, mem_word(32'h3000), 0, 6, 32'hFFFF_FFFC);
        add(0, 0, 1,  1, 32'hFFFF_FFFC, 32'h0, 1, 6, 32'h0000_0000);
        add(0, 0, 0,  1, 32'hFFFF_FFFC, 32'h0, 1, 6, 32'h0000_0000);

        repeat (2) @(negedge clk);
        checkAll("reset", 0, 32'h0, 32'h0, 0, 32'h0, 32'h3000);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].redirect, vecs[i].rpc, vecs[i].d_ready);
            checkAll($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_fpc,
                     vecs[i].e_instr, vecs[i].e_exc, vecs[i].e_cnt, vecs[i].e_pc);
        end

        // Asynchronous reset between edges while stalled: outputs clear without a clock.
        #2 reset = 1'b1;
        #1 checkAll("async_rst", 0, 32'h0, 32'h0, 0, 32'h0, 32'h3000);

        // Reset held across an edge with a pending redirect and ready.
        applyStimulus(1, 32'h3100, 1);
        checkAll("rst_hold", 0, 32'h0, 32'h0, 0, 32'h0, 32'h3000);

        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 32'h0, 1);
        checkAll("post_rst", 1, 32'h3000, mem_word(32'h3000), 0, 32'h0, 32'h3004);

        // Counter wrap: preload all-ones, then one handoff.
        @(negedge clk);
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        #1 release dut.fetch_cnt;
        applyStimulus(0, 32'h0, 1);
        checkAll("cnt_wrap", 1, 32'h3004, mem_word(32'h3004), 0, 32'h0, 32'h3008);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
